// File: rtl/pipe_data_select_pkg.sv
// Shared datapath select defaults and mux-select encodings for the multicycle datapath.
// Holds widths, the return-address register number and the RegDst/ALUSrcB encodings.
package pipe_data_select_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int REG_ADDR_W     = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ADDR_RA = 5'h1f;

  typedef enum logic [1:0] {
    REGDST_RA = 2'b00,
    REGDST_RT = 2'b01,
    REGDST_RD = 2'b10
  } regdst_e;

  typedef enum logic [1:0] {
    ALUSRCB_REG    = 2'b00,
    ALUSRCB_FOUR   = 2'b01,
    ALUSRCB_IMM    = 2'b10,
    ALUSRCB_IMM_SH = 2'b11
  } alusrcb_e;

  // True when a select value names an existing channel.
  function automatic logic sel_in_range(input int sel, input int num_in);
    return sel < num_in;
  endfunction

endpackage

// File: rtl/pipe_data_select_if.sv
// Handshake bundle of the registered selector: upstream offer, flush and downstream consume.
// master = datapath control side, slave = the selector.
interface pipe_data_select_if
  import pipe_data_select_pkg::*;
#(
  parameter int WIDTH  = DATA_W_DEFAULT,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
);

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data, in_sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );

endinterface

// File: rtl/pipe_data_select_comb.sv
// Purely combinational NUM_IN-way selector; selects >= NUM_IN yield DEFAULT_VAL truncated to WIDTH.
// Zero latency, no handshake; usable directly as an unregistered datapath mux.
module data_select_comb
  import pipe_data_select_pkg::*;
#(
  parameter int          WIDTH       = DATA_W_DEFAULT,
  parameter int          NUM_IN      = 4,
  parameter int          SEL_W       = 2,
  parameter logic [31:0] DEFAULT_VAL = 32'h0000001f
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data
);

  localparam logic [WIDTH-1:0] DEF_W = WIDTH'(DEFAULT_VAL);

  always_comb begin
    out_data = DEF_W;
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(sel) == k) out_data = in_data[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/pipe_data_select.sv
// Registered N-way selector with a one-entry valid/ready stage: 1-cycle latency, full throughput,
// in_ready = !out_valid || out_ready. Optional sticky sel_err under DATA_SELECT_RANGE_CHK_EN.
module pipe_data_select
  import pipe_data_select_pkg::*;
#(
  parameter int          WIDTH       = DATA_W_DEFAULT,
  parameter int          NUM_IN      = 4,
  parameter int          SEL_W       = 2,
  parameter logic [31:0] DEFAULT_VAL = 32'h0000001f
) (
  input  logic                clk,
  input  logic                rst_n,
  pipe_data_select_if.slave   bus
`ifdef DATA_SELECT_RANGE_CHK_EN
  ,
  output logic                sel_err
`endif
);

  logic [WIDTH-1:0] sel_val;
  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] sel_q;
  logic             valid_q;
  logic             accept;
  logic             consume;

  data_select_comb #(
    .WIDTH       (WIDTH),
    .NUM_IN      (NUM_IN),
    .SEL_W       (SEL_W),
    .DEFAULT_VAL (DEFAULT_VAL)
  ) u_select (
    .in_data  (bus.in_data),
    .sel      (bus.in_sel),
    .out_data (sel_val)
  );

  assign bus.in_ready  = !valid_q || bus.out_ready;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
  assign bus.out_valid = valid_q;

  assign accept  = bus.in_valid && bus.in_ready;
  assign consume = valid_q && bus.out_ready;

  // Flush wins over a simultaneous accept; the offered value is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      data_q  <= sel_val;
      sel_q   <= bus.in_sel;
      valid_q <= 1'b1;
    end else if (consume) begin
      valid_q <= 1'b0;
    end
  end

`ifdef DATA_SELECT_RANGE_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else if (accept && !sel_in_range(int'(bus.in_sel), NUM_IN)) begin
      sel_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_data_select.sv
// Scoreboard bench: driver pushes expected entries from a channel-array model, negedge monitors pop and compare.
module tb_pipe_data_select;

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_data_select_if #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) bus ();
  pipe_data_select_if #(.WIDTH(5),  .NUM_IN(3), .SEL_W(2)) sbus ();

  pipe_data_select #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .DEFAULT_VAL(32'h1f)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  pipe_data_select #(.WIDTH(5), .NUM_IN(3), .SEL_W(2), .DEFAULT_VAL(32'h1f)) dut_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sbus)
  );

  exp_t q[$];
  exp_t q2[$];
  int checks = 0;
  int errors = 0;
  logic [127:0] ch_all;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_big(input logic [127:0] d, input logic [1:0] s);
    logic [31:0] ch[4];
    for (int i = 0; i < 4; i++) ch[i] = d[i*32 +: 32];
    return ch[s];
  endfunction

  function automatic logic [4:0] ref_small(input logic [14:0] d, input logic [1:0] s);
    logic [4:0] ch[3];
    for (int i = 0; i < 3; i++) ch[i] = d[i*5 +: 5];
    if (s < 2'd3) return ch[s];
    return 5'h1f;
  endfunction

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input logic v, input logic [1:0] s, input logic [127:0] d,
                      input logic f, input logic r);
    logic acc;
    logic [1:0] s2;
    logic [14:0] d2;
    exp_t e, e2;
    s2 = 2'($urandom_range(0, 3));
    d2 = 15'($urandom);
    bus.in_valid = v; bus.in_sel = s; bus.in_data = d; bus.flush = f; bus.out_ready = r;
    sbus.in_valid = 1'b1; sbus.in_sel = s2; sbus.in_data = d2; sbus.flush = 1'b0; sbus.out_ready = 1'b1;
    acc = v && (q.size() == 0 || r);
    e.sel = s;  e.data = ref_big(d, s);
    e2.sel = s2; e2.data = {27'b0, ref_small(d2, s2)};
    @(posedge clk); #1;
    if (f) q.delete();
    else if (acc) q.push_back(e);
    q2.push_back(e2);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      exp_t h;
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(bus.in_ready), 32'(q.size() == 0 || bus.out_ready));
      if (bus.out_valid && q.size() != 0) begin
        h = q[0];
        chk("out_data", bus.out_data, h.data);
        chk("out_sel", 32'(bus.out_sel), 32'(h.sel));
        if (bus.out_ready) void'(q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      exp_t h;
      chk("small_out_valid", 32'(sbus.out_valid), 32'(q2.size() != 0));
      if (sbus.out_valid && q2.size() != 0) begin
        h = q2[0];
        chk("small_out_data", 32'(sbus.out_data), h.data);
        chk("small_out_sel", 32'(sbus.out_sel), 32'(h.sel));
        void'(q2.pop_front());
      end
    end
  end

  initial begin
    ch_all = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    bus.in_valid = 1'b0; bus.in_sel = '0; bus.in_data = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    sbus.in_valid = 1'b0; sbus.in_sel = '0; sbus.in_data = '0; sbus.flush = 1'b0; sbus.out_ready = 1'b1;

    #3;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out_data", bus.out_data, 32'd0);
    chk("reset_out_sel", 32'(bus.out_sel), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic select, then back-pressure with sel=1 held for 5 cycles.
    step(1'b1, 2'd2, ch_all, 1'b0, 1'b1);
    step(1'b1, 2'd1, ch_all, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 2'($urandom_range(0, 3)), rnd128(), 1'b0, 1'b0);
    step(1'b1, 2'd3, ch_all, 1'b0, 1'b1);
    step(1'b0, 2'd0, ch_all, 1'b0, 1'b1);

    // Flush while stalled, then flush while consuming; offers are dropped.
    step(1'b1, 2'd0, ch_all, 1'b0, 1'b0);
    step(1'b1, 2'd0, ch_all, 1'b1, 1'b0);
    step(1'b1, 2'd1, ch_all, 1'b0, 1'b0);
    step(1'b1, 2'd2, ch_all, 1'b1, 1'b1);
    step(1'b0, 2'd0, ch_all, 1'b0, 1'b1);

    // Streaming, one entry per cycle.
    for (int i = 0; i < 8; i++) step(1'b1, 2'(i % 4), ch_all, 1'b0, 1'b1);
    step(1'b0, 2'd0, ch_all, 1'b0, 1'b1);

    // Asynchronous reset mid-cycle with an entry held.
    step(1'b1, 2'd1, ch_all, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    q.delete();
    q2.delete();
    #1;
    chk("midreset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midreset_out_data", bus.out_data, 32'd0);
    chk("midreset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midreset_small_valid", 32'(sbus.out_valid), 32'd0);
    sbus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), rnd128(),
           $urandom_range(0, 15) == 0, $urandom_range(0, 9) < 6);
    end

    step(1'b0, 2'd0, ch_all, 1'b0, 1'b1);
    step(1'b0, 2'd0, ch_all, 1'b0, 1'b1);
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_data_select.md
Name: pipe_data_select

Overview:
- Parametrised, registered N-way data selector for the multicycle datapath.
- Generalises the fixed 2/3/4-input 5- and 32-bit selectors to WIDTH bits and NUM_IN channels.
- Adds a one-entry pipeline register with valid/ready handshake, so a selected operand (register address, ALU operand, PC source) can be held across FSM states.
- Sits between datapath sources and the consumer stage (ALU, register file write port, PC).

Parameters:
- WIDTH, 32, data width of each input channel and of the output.
- NUM_IN, 4, number of input channels; legal range 2..16.
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN.
- DEFAULT_VAL, 32'h0000001f, value driven for a select >= NUM_IN; truncated to WIDTH (5'h1f when WIDTH=5).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  NUM_IN*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
- in_sel  in  SEL_W  channel select, sampled with in_valid.
- in_valid  in  1  upstream offers a selection.
- in_ready  out  1  block can accept a selection this cycle.
- flush  in  1  synchronous discard of the held entry.
- out_data  out  WIDTH  registered selected value.
- out_sel  out  SEL_W  select that produced out_data.
- out_valid  out  1  out_data holds an unconsumed entry.
- out_ready  in  1  downstream consumes the entry.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_sel=0; error state (if built) cleared. Reset takes effect immediately, mid-transfer included; any held entry is lost.
- Combinational select:
  - sel_val = channel in_sel when in_sel < NUM_IN.
  - sel_val = DEFAULT_VAL[WIDTH-1:0] otherwise.
- in_ready = !out_valid || out_ready (combinational, no bubble on back-to-back transfers).
- Accept occurs when in_valid && in_ready. On the next clk edge: out_data <= sel_val, out_sel <= in_sel, out_valid <= 1.
- Latency: 1 cycle from accept to out_valid. Sustained throughput is 1 entry per cycle when out_ready is held high.
- Consume occurs when out_valid && out_ready. With no simultaneous accept, out_valid <= 0 and out_data/out_sel hold their last values.
- Simultaneous consume and accept: the new entry replaces the old one; out_valid stays 1.
- Stall (out_valid=1, out_ready=0): in_ready=0; out_data and out_sel are stable and must not change.
- Flush:
  - flush=1 forces out_valid <= 0 and overrides accept.
  - in_ready is unaffected by flush, but anything offered in a flush cycle is dropped.
- out_data is never X after reset. Upstream data changing while in_valid=0 has no effect.

Optional Feature:
- Macro DATA_SELECT_RANGE_CHK_EN.
- When defined:
  - Adds output sel_err (1 bit, reset 0).
  - sel_err is sticky: it sets on the clock edge after any accept with in_sel >= NUM_IN.
  - It clears only on rst_n.
  - The out-of-range accept still completes, with DEFAULT_VAL.
- When not defined: no sel_err port, no extra flops; out-of-range selects silently yield DEFAULT_VAL.

Decomposition:
- Shared package holds the defaults (DATA_W_DEFAULT=32, REG_ADDR_W=5, REG_ADDR_RA=5'h1f) and the datapath mux-select encodings, for example RegDst (00 = $31, 01 = rt, 10 = rd) and ALUSrc.
- One natural sub-module: data_select_comb. It is the purely combinational NUM_IN-way selector with default, instantiated once and reusable by existing unregistered muxes.
- The handshake register stays in pipe_data_select.

Test Plan:
- Reset: WIDTH=32, NUM_IN=4. Assert rst_n=0 mid-cycle with out_valid=1 -> out_valid=0, out_data=0 immediately, before the next edge; in_ready=1.
- Basic select: channels = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000}, in_sel=2, in_valid=1, out_ready=1 -> next cycle out_data=32'hCCCC0002, out_sel=2, out_valid=1.
- Back-pressure: hold out_ready=0 after an accept of sel=1 -> in_ready=0; out_data stays 32'hBBBB0001 for 5 cycles despite in_sel/in_data changes. Release out_ready with in_valid=1, sel=3 -> next cycle out_data=32'hDDDD0003 with no bubble.
- Out-of-range: WIDTH=5, NUM_IN=3, in_sel=3 accepted -> out_data=5'h1f. With DATA_SELECT_RANGE_CHK_EN, sel_err=1 and stays 1 after later legal selects until rst_n.
- Flush: out_valid=1, then flush=1 together with in_valid=1, sel=0 -> next cycle out_valid=0; the flushed offer is not captured.
- Streaming: in_valid=1 and out_ready=1 for 8 cycles, sel cycling 0..3 -> 8 outputs in order, one per cycle, each matching its channel.
